// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
// Holds the FSM states, pattern mode codes and LFSR tap selection.
package axis_pkt_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      STOPPING
   } state_e;

   localparam logic [1:0] MODE_CNT  = 2'd0;
   localparam logic [1:0] MODE_LFSR = 2'd1;
   localparam logic [1:0] MODE_FILL = 2'd2;

   // Maximal-length Galois tap masks; unsupported widths get no taps.
   function automatic logic [63:0] lfsrTaps(input int width);
      case (width)
         8:       return 64'h0000_0000_0000_00B8;
         16:      return 64'h0000_0000_0000_B400;
         32:      return 64'h0000_0000_A300_0000;
         64:      return 64'hD800_0000_0000_0000;
         default: return 64'h0;
      endcase
   endfunction

endpackage

// File: rtl/axis_lfsr.sv
// Right-shifting Galois LFSR with synchronous seed load and advance enable.
// Load takes priority over advance so a new run always begins from its seed.
module axis_lfsr
   import axis_pkt_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   input  logic                  advance_i,
   output logic [DATA_WIDTH-1:0] state_o
);

   localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsrTaps(DATA_WIDTH));

   logic [DATA_WIDTH-1:0] lfsr_q;
   logic [DATA_WIDTH-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = seed_i;
      end else if (advance_i) begin
         lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream master packet generator with run-time length, count and pattern.
// Holds tdata/tlast under backpressure and only stops at packet boundaries.
module axis_pkt_gen
   import axis_pkt_gen_pkg::*;
#(
   parameter int  DATA_WIDTH  = 32,
   parameter int  MAX_PKT_LEN = 256,
   parameter int  CNT_W       = 16,
   localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic [LEN_W-1:0]      cfg_pkt_len,
   input  logic [CNT_W-1:0]      cfg_num_pkts,
   input  logic [1:0]            cfg_mode,
   input  logic [DATA_WIDTH-1:0] cfg_fill,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_W-1:0]      pkt_count
);

   state_e                state_q;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      beatIdx_q;
   logic [CNT_W-1:0]      numPkts_q;
   logic [CNT_W-1:0]      pktCount_q;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] fill_q;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic                  done_q;

   logic [LEN_W-1:0]      startLen;
   logic [LEN_W-1:0]      nextIdx;
   logic [LEN_W-1:0]      lenM1;
   logic [DATA_WIDTH-1:0] seed;
   logic [CNT_W-1:0]      pktCountInc;
   logic                  handshake;
   logic                  finalPkt;
   logic                  endRun;
   logic                  lfsrLoad;
   logic [DATA_WIDTH-1:0] lfsrState;

   // Config resolution: zero length means one beat, oversize is clamped.
   always_comb begin
      startLen = cfg_pkt_len;
      if (cfg_pkt_len == '0) begin
         startLen = LEN_W'(1);
      end else if (cfg_pkt_len > LEN_W'(MAX_PKT_LEN)) begin
         startLen = LEN_W'(MAX_PKT_LEN);
      end
      seed        = (cfg_fill == '0) ? DATA_WIDTH'(1) : cfg_fill;
      handshake   = tvalid_q && m_tready;
      nextIdx     = beatIdx_q + 1'b1;
      lenM1       = len_q - 1'b1;
      pktCountInc = pktCount_q + 1'b1;
      finalPkt    = (numPkts_q != '0) && (pktCountInc == numPkts_q);
      endRun      = finalPkt || (state_q == STOPPING) || stop;
      lfsrLoad    = (state_q == IDLE) && start;
   end

   axis_lfsr #(
      .DATA_WIDTH(DATA_WIDTH)
   ) uLfsr (
      .clk       (clk),
      .reset     (reset),
      .load_i    (lfsrLoad),
      .seed_i    (seed),
      .advance_i (handshake),
      .state_o   (lfsrState)
   );

   // Main control: a stop seen while SEND arms STOPPING, but a run-ending
   // tlast handshake in the same cycle overrides it and returns to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         beatIdx_q  <= '0;
         numPkts_q  <= '0;
         pktCount_q <= '0;
         mode_q     <= MODE_CNT;
         fill_q     <= '0;
         cnt_q      <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= SEND;
                  len_q      <= startLen;
                  numPkts_q  <= cfg_num_pkts;
                  mode_q     <= cfg_mode;
                  fill_q     <= cfg_fill;
                  beatIdx_q  <= '0;
                  cnt_q      <= '0;
                  pktCount_q <= '0;
                  tvalid_q   <= 1'b1;
                  tlast_q    <= (startLen == LEN_W'(1));
               end
            end
            SEND, STOPPING: begin
               if (stop && (state_q == SEND)) begin
                  state_q <= STOPPING;
               end
               if (handshake) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (tlast_q) begin
                     pktCount_q <= pktCountInc;
                     beatIdx_q  <= '0;
                     if (endRun) begin
                        state_q  <= IDLE;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        done_q   <= 1'b1;
                     end else begin
                        tlast_q <= (len_q == LEN_W'(1));
                     end
                  end else begin
                     beatIdx_q <= nextIdx;
                     tlast_q   <= (nextIdx == lenM1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      case (mode_q)
         MODE_LFSR: m_tdata = lfsrState;
         MODE_FILL: m_tdata = fill_q;
         default:   m_tdata = cnt_q;
      endcase
   end

   assign m_tvalid  = tvalid_q;
   assign m_tlast   = tlast_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign pkt_count = pktCount_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: scenario tasks compare captured beats
// against a queue-based model built directly from the pattern/length rules.
module tb_axis_pkt_gen;

   localparam int DW     = 32;
   localparam int MAXLEN = 16;
   localparam int CW     = 8;
   localparam int LW     = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          stop;
   logic [LW-1:0] cfg_pkt_len;
   logic [CW-1:0] cfg_num_pkts;
   logic [1:0]    cfg_mode;
   logic [DW-1:0] cfg_fill;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic          busy;
   logic          done;
   logic [CW-1:0] pkt_count;

   int checks = 0;
   int errors = 0;

   int negCycle  = 0;
   int doneCount = 0;
   int doneNeg   = 0;
   int startNeg  = 0;

   logic [DW-1:0] gotData[$];
   bit            gotLast[$];
   int            gotNeg[$];
   logic [DW-1:0] expData[$];
   bit            expLast[$];

   axis_pkt_gen #(
      .DATA_WIDTH  (DW),
      .MAX_PKT_LEN (MAXLEN),
      .CNT_W       (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .cfg_pkt_len  (cfg_pkt_len),
      .cfg_num_pkts (cfg_num_pkts),
      .cfg_mode     (cfg_mode),
      .cfg_fill     (cfg_fill),
      .m_tdata      (m_tdata),
      .m_tvalid     (m_tvalid),
      .m_tready     (m_tready),
      .m_tlast      (m_tlast),
      .busy         (busy),
      .done         (done),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   // Capture every beat that will handshake on the coming rising edge.
   always @(negedge clk) begin
      negCycle <= negCycle + 1;
      if (!reset) begin
         if (m_tvalid && m_tready) begin
            gotData.push_back(m_tdata);
            gotLast.push_back(m_tlast);
            gotNeg.push_back(negCycle);
         end
         if (done) begin
            doneCount <= doneCount + 1;
            doneNeg   <= negCycle;
         end
      end
   end

   // Expected stream: length resolution, then per-beat pattern by mode.
   task automatic buildModel(input int len, input int num, input int mode, input logic [DW-1:0] fill);
      int            effLen;
      logic [DW-1:0] s;
      logic [DW-1:0] ctr;
      expData.delete();
      expLast.delete();
      effLen = (len == 0) ? 1 : ((len > MAXLEN) ? MAXLEN : len);
      s      = (fill == 0) ? 32'd1 : fill;
      ctr    = '0;
      for (int p = 0; p < num; p++) begin
         for (int b = 0; b < effLen; b++) begin
            if (mode == 1)      expData.push_back(s);
            else if (mode == 2) expData.push_back(fill);
            else                expData.push_back(ctr);
            expLast.push_back(b == effLen - 1);
            ctr = ctr + 1;
            s   = s[0] ? ((s >> 1) ^ 32'hA300_0000) : (s >> 1);
         end
      end
   endtask

   task automatic applyStimulus(input int len, input int num, input int mode,
                                input logic [DW-1:0] fill, input bit withStop);
      gotData.delete();
      gotLast.delete();
      gotNeg.delete();
      cfg_pkt_len  = LW'(len);
      cfg_num_pkts = CW'(num);
      cfg_mode     = 2'(mode);
      cfg_fill     = fill;
      start        = 1'b1;
      stop         = withStop;
      @(posedge clk); #1;
      start    = 1'b0;
      stop     = 1'b0;
      startNeg = negCycle;
   endtask

   task automatic waitDone(input int budget, input bit randReady, output bit ok);
      int d0;
      d0 = doneCount;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (randReady) m_tready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         if (doneCount != d0) begin
            ok = 1'b1;
            break;
         end
      end
      m_tready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_tvalid got %b want 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_tlast got %b want 0", m_tlast); end
      checks++; if (m_tdata !== '0) begin errors++; $display("[TB] FAIL rst_tdata got %h want 0", m_tdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got %b want 0", done); end
      checks++; if (pkt_count !== '0) begin errors++; $display("[TB] FAIL rst_pktcount got %0d want 0", pkt_count); end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL idle_tvalid got %b want 0", m_tvalid); end
   endtask

   task automatic test_counter();
      bit ok;
      int d0;
      d0 = doneCount;
      buildModel(16, 2, 0, '0);
      applyStimulus(16, 2, 0, '0, 1'b0);
      waitDone(200, 1'b0, ok);
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL cnt_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 32) begin errors++; $display("[TB] FAIL cnt_beats got %0d want 32", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL cnt_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
      if (gotNeg.size() == 32) begin
         checks++; if (gotNeg[0] !== startNeg) begin errors++; $display("[TB] FAIL cnt_first_cycle got %0d want %0d", gotNeg[0], startNeg); end
         checks++; if (gotNeg[31] - gotNeg[0] !== 31) begin errors++; $display("[TB] FAIL cnt_span got %0d want 31", gotNeg[31] - gotNeg[0]); end
      end
      checks++; if (pkt_count !== 8'd2) begin errors++; $display("[TB] FAIL cnt_pktcount got %0d want 2", pkt_count); end
      checks++; if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL cnt_done_pulses got %0d want 1", doneCount - d0); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL cnt_tvalid_after got %b want 0", m_tvalid); end
   endtask

   task automatic test_backpressure();
      bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit            stalled;
      bit            finished;
      logic [DW-1:0] heldData;
      logic          heldLast;
      int            d0;
      d0       = doneCount;
      stalled  = 1'b0;
      finished = 1'b0;
      heldData = '0;
      heldLast = 1'b0;
      buildModel(4, 1, 0, '0);
      applyStimulus(4, 1, 0, '0, 1'b0);
      for (int k = 0; k < 60 && !finished; k++) begin
         m_tready = pat[k % 4];
         @(negedge clk);
         if (stalled && m_tvalid) begin
            checks++;
            if (m_tdata !== heldData || m_tlast !== heldLast) begin
               errors++; $display("[TB] FAIL bp_hold got %h/%0b want %h/%0b", m_tdata, m_tlast, heldData, heldLast);
            end
         end
         stalled  = m_tvalid && !m_tready;
         heldData = m_tdata;
         heldLast = m_tlast;
         @(posedge clk); #1;
         if (doneCount != d0) finished = 1'b1;
      end
      m_tready = 1'b1;
      checks++; if (finished !== 1'b1) begin errors++; $display("[TB] FAIL bp_timeout got %b want 1", finished); end
      checks++; if (gotData.size() !== 4) begin errors++; $display("[TB] FAIL bp_beats got %0d want 4", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL bp_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
   endtask

   task automatic test_stop_fill();
      bit ok;
      bit reached;
      reached = 1'b0;
      m_tready = 1'b1;
      buildModel(8, 2, 2, 32'hA5A5_A5A5);
      applyStimulus(8, 0, 2, 32'hA5A5_A5A5, 1'b0);
      for (int i = 0; i < 50 && !reached; i++) begin
         if (gotData.size() >= 11) reached = 1'b1;
         else begin @(posedge clk); #1; end
      end
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      waitDone(100, 1'b0, ok);
      @(posedge clk); #1;
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL stop_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 16) begin errors++; $display("[TB] FAIL stop_beats got %0d want 16", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL stop_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
      checks++; if (pkt_count !== 8'd2) begin errors++; $display("[TB] FAIL stop_pktcount got %0d want 2", pkt_count); end
      if (gotNeg.size() > 0) begin
         checks++; if (doneNeg !== gotNeg[gotNeg.size()-1] + 1) begin errors++; $display("[TB] FAIL stop_done_time got %0d want %0d", doneNeg, gotNeg[gotNeg.size()-1] + 1); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy got %b want 0", busy); end
   endtask

   task automatic test_len_edges();
      bit ok;
      // Zero length becomes single-beat packets.
      buildModel(0, 3, 0, '0);
      applyStimulus(0, 3, 0, '0, 1'b0);
      waitDone(50, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL len0_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 3) begin errors++; $display("[TB] FAIL len0_beats got %0d want 3", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL len0_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
      checks++; if (pkt_count !== 8'd3) begin errors++; $display("[TB] FAIL len0_pktcount got %0d want 3", pkt_count); end
      // Oversize length is clamped to the maximum.
      buildModel(20, 1, 0, '0);
      applyStimulus(20, 1, 0, '0, 1'b0);
      waitDone(200, 1'b1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL clamp_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== MAXLEN) begin errors++; $display("[TB] FAIL clamp_beats got %0d want %0d", gotData.size(), MAXLEN); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL clamp_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
   endtask

   task automatic test_lfsr();
      bit ok;
      buildModel(15, 17, 1, '0);
      applyStimulus(15, 17, 1, '0, 1'b0);
      waitDone(1500, 1'b1, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL lfsr_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 255) begin errors++; $display("[TB] FAIL lfsr_beats got %0d want 255", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL lfsr_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
         checks++;
         if (gotData[i] === '0) begin
            errors++; $display("[TB] FAIL lfsr_zero%0d got %h want nonzero", i, gotData[i]);
         end
      end
   endtask

   task automatic test_start_stop_ctrl();
      bit ok;
      // Start and stop together in IDLE: start wins and the run completes.
      buildModel(2, 1, 0, '0);
      applyStimulus(2, 1, 0, '0, 1'b1);
      waitDone(50, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL ss_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 2) begin errors++; $display("[TB] FAIL ss_beats got %0d want 2", gotData.size()); end
      // A start while busy must not disturb the running configuration.
      buildModel(4, 2, 0, '0);
      applyStimulus(4, 2, 0, '0, 1'b0);
      @(posedge clk); #1;
      cfg_pkt_len = 5'd1;
      cfg_mode    = 2'd2;
      cfg_fill    = 32'hDEAD_BEEF;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      waitDone(100, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL busy_start_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 8) begin errors++; $display("[TB] FAIL busy_start_beats got %0d want 8", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL busy_start_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
   endtask

   task automatic test_random();
      bit            ok;
      int            mode;
      int            len;
      int            num;
      logic [DW-1:0] fill;
      for (int r = 0; r < 5; r++) begin
         mode = $urandom_range(0, 3);
         len  = $urandom_range(0, 20);
         num  = $urandom_range(1, 3);
         fill = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
         buildModel(len, num, mode, fill);
         applyStimulus(len, num, mode, fill, 1'b0);
         waitDone(400, 1'b1, ok);
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_timeout got %b want 1", r, ok); end
         checks++; if (gotData.size() !== expData.size()) begin errors++; $display("[TB] FAIL rnd%0d_beats got %0d want %0d", r, gotData.size(), expData.size()); end
         for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
            checks++;
            if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
               errors++; $display("[TB] FAIL rnd%0d_beat%0d mode %0d got %h/%0b want %h/%0b", r, i, mode, gotData[i], gotLast[i], expData[i], expLast[i]);
            end
         end
         checks++; if (pkt_count !== CW'(num)) begin errors++; $display("[TB] FAIL rnd%0d_pktcount got %0d want %0d", r, pkt_count, num); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      applyStimulus(16, 0, 2, 32'h1234_5678, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tvalid got %b want 0", m_tvalid); end
      checks++; if (m_tdata !== '0) begin errors++; $display("[TB] FAIL midrst_tdata got %h want 0", m_tdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      buildModel(4, 1, 0, '0);
      applyStimulus(4, 1, 0, '0, 1'b0);
      checks++; if (m_tdata !== '0) begin errors++; $display("[TB] FAIL restart_tdata got %h want 0", m_tdata); end
      checks++; if (pkt_count !== '0) begin errors++; $display("[TB] FAIL restart_pktcount got %0d want 0", pkt_count); end
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL restart_tvalid got %b want 1", m_tvalid); end
      waitDone(50, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL restart_timeout got %b want 1", ok); end
      checks++; if (gotData.size() !== 4) begin errors++; $display("[TB] FAIL restart_beats got %0d want 4", gotData.size()); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
         checks++;
         if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
            errors++; $display("[TB] FAIL restart_beat%0d got %h/%0b want %h/%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      stop         = 1'b0;
      m_tready     = 1'b1;
      cfg_pkt_len  = '0;
      cfg_num_pkts = '0;
      cfg_mode     = '0;
      cfg_fill     = '0;
      $display("[TB] starting axis_pkt_gen bench");
      test_reset();
      test_counter();
      test_backpressure();
      test_stop_fill();
      test_len_edges();
      test_lfsr();
      test_start_stop_ctrl();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
- Parametrised AXI-Stream master packet generator; successor to the fixed 16-beat counter source.
- Adds run-time packet length, packet count, selectable data pattern (counter / LFSR / fill), start/stop control, status outputs and strict AXI-Stream hold-under-backpressure.
- Sits at the head of stream test datapaths as a stimulus source for downstream slaves, FIFOs and width converters.

Parameters:
- DATA_WIDTH, 32, tdata width; legal values 8, 16, 32, 64 (LFSR taps exist only for these).
- MAX_PKT_LEN, 256, largest packet in beats; LEN_W = $clog2(MAX_PKT_LEN+1).
- CNT_W, 16, width of the packet-count config and the status counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; honoured only in IDLE.
- stop  in  1  1-cycle pulse; graceful stop at the next packet boundary.
- cfg_pkt_len  in  LEN_W  beats per packet; sampled on start.
- cfg_num_pkts  in  CNT_W  packets to send, 0 = run until stop; sampled on start.
- cfg_mode  in  2  0 = counter, 1 = LFSR, 2 = fill, 3 = reserved (treated as counter); sampled on start.
- cfg_fill  in  DATA_WIDTH  fill value / LFSR seed; sampled on start.
- m_tdata  out  DATA_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last beat of a packet.
- busy  out  1  high in SEND and STOPPING.
- done  out  1  1-cycle pulse at end of run.
- pkt_count  out  CNT_W  completed packets this run; wraps at 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): m_tvalid, m_tlast, m_tdata, busy, done and pkt_count = 0; state = IDLE; LFSR = 0. Reset mid-packet drops tvalid immediately; this is permitted.
- Handshake = m_tvalid && m_tready. While m_tvalid = 1 and no handshake, m_tdata and m_tlast hold stable. m_tvalid never deasserts without a handshake, except on reset.
- Config resolution at start:
  - cfg_pkt_len = 0 is treated as 1.
  - cfg_pkt_len > MAX_PKT_LEN is clamped to MAX_PKT_LEN.
  - In LFSR mode, a seed of 0 is replaced by 1.
- States:
  - IDLE: on start, latch config, clear pkt_count and beat index → SEND. m_tvalid rises the cycle after start, carrying beat 0.
  - SEND: on each handshake, advance to the next beat. m_tlast = 1 exactly when beat index == pkt_len-1. After the tlast handshake, increment pkt_count and reset the beat index to 0.
  - Next packet begins with no bubble: tvalid stays 1 the cycle after tlast. Throughput is 1 beat/cycle with m_tready held high.
  - A stop pulse in SEND → STOPPING. If stop coincides with the tlast handshake, the run ends at that boundary.
  - STOPPING: behaves as SEND but ends at the next tlast handshake. Packets are never truncated.
  - Run end (final packet reached, or the STOPPING boundary): on the tlast handshake, m_tvalid = 0 next cycle, done = 1 for one cycle, state = IDLE. pkt_count holds until the next start.
- Data patterns:
  - Counter: tdata = running beat count modulo 2^DATA_WIDTH, starting at 0 on start and continuing across packets (no per-packet restart).
  - LFSR: Galois, maximal-length taps from the package. First beat = seed; advance once per handshake.
  - Fill: every beat = cfg_fill.
- pkt_len = 1: every beat carries tlast.
- start while busy is ignored. start and stop in the same IDLE cycle: start wins, stop is ignored.

Decomposition:
- Package axis_pkt_gen_pkg:
  - state enum (IDLE, SEND, STOPPING);
  - mode constants (MODE_CNT = 0, MODE_LFSR = 1, MODE_FILL = 2);
  - function returning the LFSR tap mask per width (8: 0xB8, 16: 0xB400, 32: 0xA3000000, 64: 0xD800000000000000).
- One natural sub-module, axis_lfsr: load, advance enable, DATA_WIDTH state output.

Test Plan:
- len 16, num 2, mode counter, tready = 1 → 32 beats in 32 consecutive cycles; tdata 0..31; tlast on beats 15 and 31; pkt_count = 2; single done pulse.
- len 4, num 1, tready toggling 1-0-0-1 → tdata/tlast stable during stalls; exactly 4 handshakes with data 0,1,2,3; tlast only on data 3.
- len 8, num 0, mode fill 0xA5A5A5A5; stop on beat 3 of packet 2 → packet 2 completes all 8 beats; pkt_count = 2; done one cycle after its tlast.
- len 0, num 3 → three 1-beat packets, each with tlast = 1; pkt_count = 3.
- mode LFSR, DATA_WIDTH 8, seed 0 → beats 0x01, 0xB8, 0x5C, …; no beat equals 0 over 255 beats.
- reset asserted mid-packet → all outputs 0 immediately; a subsequent start restarts with tdata = 0 and pkt_count = 0.
